// File: rtl/multicycle_controller_pkg.sv
// ----------------------------------------------------------------------------
// multicycle_controller_pkg
// Shared definitions for the multi-cycle RV32I control path. It holds the
// opcode constants, the controller state type, the datapath mux encodings and
// the ALU operation codes the controller drives.
// There are no ports. The helper isMemState() marks the states that wait on
// the memory ready handshake.
// ----------------------------------------------------------------------------
package multicycle_controller_pkg;

    // Major opcodes (instruction bits 6:0)
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic [3:0] {
        FETCH,
        DECODE,
        MEMADR,
        MEMREAD,
        MEMWB,
        MEMWRITE,
        EXECUTER,
        EXECUTEI,
        ALUWB,
        BEQ,
        JAL,
        HALT
    } stateT;

    // ALU input A select
    localparam logic [1:0] ASEL_PC    = 2'b00;
    localparam logic [1:0] ASEL_OLDPC = 2'b01;
    localparam logic [1:0] ASEL_RS1   = 2'b10;

    // ALU input B select
    localparam logic [1:0] BSEL_RS2  = 2'b00;
    localparam logic [1:0] BSEL_IMM  = 2'b01;
    localparam logic [1:0] BSEL_FOUR = 2'b10;

    // Register file write data select
    localparam logic [1:0] WDSEL_ALUOUT    = 2'b00;
    localparam logic [1:0] WDSEL_MEMDATA   = 2'b01;
    localparam logic [1:0] WDSEL_ALURESULT = 2'b10;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b1000;

    // States that hold a memory request open until the memory accepts it
    function automatic logic isMemState(input stateT s);
        return (s == FETCH) || (s == MEMREAD) || (s == MEMWRITE);
    endfunction

endpackage

// File: rtl/multicycle_controller_alu_decoder.sv
// ----------------------------------------------------------------------------
// alu_decoder
// Combinational selection of the ALU operation for the current controller
// state.
//   i_state             current controller state
//   i_funct3            funct3 field of the instruction
//   i_funct7bit5        instruction bit 30
//   o_aluLogicOperation ALU operation code (same encoding as the ALU)
// ----------------------------------------------------------------------------
module alu_decoder
    import multicycle_controller_pkg::*;
(
    input  stateT      i_state,
    input  logic [2:0] i_funct3,
    input  logic       i_funct7bit5,
    output logic [3:0] o_aluLogicOperation
);

    always_comb begin
        o_aluLogicOperation = ALU_ADD;
        case (i_state)
            EXECUTER: o_aluLogicOperation = {i_funct7bit5, i_funct3};
            // For I-type ALU ops, bit 30 belongs to the immediate. It only
            // selects an operation for shifts (srli/srai). Without this,
            // addi with a negative immediate would decode as sub.
            EXECUTEI: o_aluLogicOperation = {(i_funct3 == 3'b101) ? i_funct7bit5 : 1'b0, i_funct3};
            BEQ:      o_aluLogicOperation = ALU_SUB;
            default:  o_aluLogicOperation = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// ----------------------------------------------------------------------------
// multicycle_controller
// Moore-style control FSM that sequences one RV32I instruction (lw, sw,
// R-type, I-type ALU, beq, jal) over 3-5 states. It drives every datapath
// enable and mux select.
//   i_clk, i_rst_n       clock; asynchronous active-low reset
//   i_operand            opcode field from the instruction register
//   i_funct3             funct3 field
//   i_funct7bit5         instruction bit 30
//   i_zero               ALU zero flag (branch decision)
//   i_memReady           memory completed the current access
//   o_pcWriteEn          PC load
//   o_adrSel             memory address: 0 = PC, 1 = ALUOut
//   o_memReadEn          memory read request
//   o_memWriteEn         memory write request
//   o_irWriteEn          load instruction register and oldPC
//   o_regWriteEn         register file write
//   o_aluInputASel       00 PC, 01 oldPC, 10 rs1
//   o_aluInputBSel       00 rs2, 01 immediate, 10 constant 4
//   o_aluLogicOperation  ALU operation
//   o_regWriteDataSel    00 ALUOut, 01 memory data reg, 10 live ALU result
//   o_halted             FSM is in HALT
//   o_memTimeout         sticky: HALT was caused by a memory timeout
//   o_state              current FSM state, for debug and checkers
// ----------------------------------------------------------------------------
module multicycle_controller
    import multicycle_controller_pkg::*;
#(
    parameter bit MEM_HANDSHAKE = 1'b1,
    parameter int MEM_TIMEOUT   = 0,
    parameter bit ILLEGAL_HALT  = 1'b1
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [6:0] i_operand,
    input  logic [2:0] i_funct3,
    input  logic       i_funct7bit5,
    input  logic       i_zero,
    input  logic       i_memReady,
    output logic       o_pcWriteEn,
    output logic       o_adrSel,
    output logic       o_memReadEn,
    output logic       o_memWriteEn,
    output logic       o_irWriteEn,
    output logic       o_regWriteEn,
    output logic [1:0] o_aluInputASel,
    output logic [1:0] o_aluInputBSel,
    output logic [3:0] o_aluLogicOperation,
    output logic [1:0] o_regWriteDataSel,
    output logic       o_halted,
    output logic       o_memTimeout,
    output stateT      o_state
);

    localparam bit TIMEOUT_EN = (MEM_TIMEOUT > 0) && MEM_HANDSHAKE;
    // Keep at least one bit so the counter is legal when the timeout is off
    localparam int CNT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

    stateT            state;
    stateT            stateNext;
    logic [CNT_W-1:0] waitCnt;
    logic [CNT_W-1:0] waitCntNext;
    logic             memTimeoutReg;
    logic             accept;
    logic             waiting;
    logic             timeoutHit;
    logic [3:0]       aluOp;

    // With no handshake the memory always completes in one cycle
    assign accept = MEM_HANDSHAKE ? i_memReady : 1'b1;

    // Ready in the limit cycle wins, because timeoutHit requires !accept
    assign waiting     = TIMEOUT_EN && isMemState(state) && !accept;
    assign timeoutHit  = waiting && (waitCnt == CNT_LAST);
    // Outside a waiting memory state the counter is held at zero. That gives
    // the clear on entry to FETCH/MEMREAD/MEMWRITE and the clear on accept.
    assign waitCntNext = waiting ? waitCnt + CNT_W'(1) : '0;

    alu_decoder u_aluDecoder (
        .i_state             (state),
        .i_funct3            (i_funct3),
        .i_funct7bit5        (i_funct7bit5),
        .o_aluLogicOperation (aluOp)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state         <= FETCH;
            waitCnt       <= '0;
            memTimeoutReg <= 1'b0;
        end else begin
            state   <= stateNext;
            waitCnt <= waitCntNext;
            if (timeoutHit) begin
                memTimeoutReg <= 1'b1;
            end
        end
    end

    always_comb begin
        stateNext           = state;
        o_pcWriteEn         = 1'b0;
        o_adrSel            = 1'b0;
        o_memReadEn         = 1'b0;
        o_memWriteEn        = 1'b0;
        o_irWriteEn         = 1'b0;
        o_regWriteEn        = 1'b0;
        o_aluInputASel      = ASEL_PC;
        o_aluInputBSel      = BSEL_RS2;
        o_aluLogicOperation = aluOp;
        o_regWriteDataSel   = WDSEL_ALUOUT;
        o_halted            = 1'b0;
        o_memTimeout        = memTimeoutReg;

        case (state)
            FETCH: begin
                o_memReadEn       = 1'b1;
                o_aluInputBSel    = BSEL_FOUR;
                o_regWriteDataSel = WDSEL_ALURESULT;
                o_irWriteEn       = accept;
                o_pcWriteEn       = accept;
                if (accept) begin
                    stateNext = DECODE;
                end else if (timeoutHit) begin
                    stateNext = HALT;
                end
            end
            DECODE: begin
                o_aluInputASel = ASEL_OLDPC;
                o_aluInputBSel = BSEL_IMM;
                case (i_operand)
                    OP_LOAD, OP_STORE: stateNext = MEMADR;
                    OP_RTYPE:          stateNext = EXECUTER;
                    OP_ITYPE:          stateNext = EXECUTEI;
                    OP_BRANCH:         stateNext = BEQ;
                    OP_JAL:            stateNext = JAL;
                    default:           stateNext = ILLEGAL_HALT ? HALT : FETCH;
                endcase
            end
            MEMADR: begin
                o_aluInputASel = ASEL_RS1;
                o_aluInputBSel = BSEL_IMM;
                stateNext      = (i_operand == OP_STORE) ? MEMWRITE : MEMREAD;
            end
            MEMREAD: begin
                o_adrSel    = 1'b1;
                o_memReadEn = 1'b1;
                if (accept) begin
                    stateNext = MEMWB;
                end else if (timeoutHit) begin
                    stateNext = HALT;
                end
            end
            MEMWB: begin
                o_regWriteEn      = 1'b1;
                o_regWriteDataSel = WDSEL_MEMDATA;
                stateNext         = FETCH;
            end
            MEMWRITE: begin
                o_adrSel     = 1'b1;
                o_memWriteEn = 1'b1;
                if (accept) begin
                    stateNext = FETCH;
                end else if (timeoutHit) begin
                    stateNext = HALT;
                end
            end
            EXECUTER: begin
                o_aluInputASel = ASEL_RS1;
                o_aluInputBSel = BSEL_RS2;
                stateNext      = ALUWB;
            end
            EXECUTEI: begin
                o_aluInputASel = ASEL_RS1;
                o_aluInputBSel = BSEL_IMM;
                stateNext      = ALUWB;
            end
            ALUWB: begin
                o_regWriteEn = 1'b1;
                stateNext    = FETCH;
            end
            BEQ: begin
                // Every branch funct3 is handled as beq
                o_aluInputASel = ASEL_RS1;
                o_aluInputBSel = BSEL_RS2;
                o_pcWriteEn    = i_zero;
                stateNext      = FETCH;
            end
            JAL: begin
                // ALUOut holds the target from DECODE. The live ALU computes
                // oldPC+4, which ALUWB then writes to rd.
                o_aluInputASel = ASEL_OLDPC;
                o_aluInputBSel = BSEL_FOUR;
                o_pcWriteEn    = 1'b1;
                stateNext      = ALUWB;
            end
            HALT: begin
                o_halted  = 1'b1;
                stateNext = HALT;
            end
            default: stateNext = FETCH;
        endcase

        // While reset is asserted, requests drop immediately without
        // waiting for a clock edge
        if (!i_rst_n) begin
            o_pcWriteEn         = 1'b0;
            o_adrSel            = 1'b0;
            o_memReadEn         = 1'b0;
            o_memWriteEn        = 1'b0;
            o_irWriteEn         = 1'b0;
            o_regWriteEn        = 1'b0;
            o_aluInputASel      = 2'b00;
            o_aluInputBSel      = 2'b00;
            o_aluLogicOperation = 4'b0000;
            o_regWriteDataSel   = 2'b00;
            o_halted            = 1'b0;
            o_memTimeout        = 1'b0;
        end
    end

    assign o_state = state;

endmodule

// File: tb/tb_multicycle_controller.sv
// ----------------------------------------------------------------------------
// tb_multicycle_controller
// Directed bench for multicycle_controller. Three instances share the
// stimulus: default parameters (m), MEM_TIMEOUT = 4 (t) and
// ILLEGAL_HALT = 0 (n). Inputs change on the falling edge. Outputs are
// sampled 1 ns later.
// Outputs are packed as {pcWe, adrSel, memRd, memWr, irWe, regWe, aSel[1:0],
// bSel[1:0], op[3:0], wdSel[1:0], halted, memTimeout}.
// ----------------------------------------------------------------------------
module tb_multicycle_controller;
    import multicycle_controller_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [6:0] opcode;
    logic [2:0] f3;
    logic       f7;
    logic       zero;
    logic       ready;

    int total = 0;
    int bad   = 0;

    // ---------------- DUT instances ----------------
    logic pcWe_m, adr_m, rd_m, wr_m, ir_m, rw_m, hlt_m, tmo_m;
    logic [1:0] a_m, b_m, wd_m;
    logic [3:0] op_m;
    stateT st_m;
    logic pcWe_t, adr_t, rd_t, wr_t, ir_t, rw_t, hlt_t, tmo_t;
    logic [1:0] a_t, b_t, wd_t;
    logic [3:0] op_t;
    stateT st_t;
    logic pcWe_n, adr_n, rd_n, wr_n, ir_n, rw_n, hlt_n, tmo_n;
    logic [1:0] a_n, b_n, wd_n;
    logic [3:0] op_n;
    stateT st_n;

    multicycle_controller dut_m (
        .i_clk(clk), .i_rst_n(rst_n), .i_operand(opcode), .i_funct3(f3),
        .i_funct7bit5(f7), .i_zero(zero), .i_memReady(ready),
        .o_pcWriteEn(pcWe_m), .o_adrSel(adr_m), .o_memReadEn(rd_m),
        .o_memWriteEn(wr_m), .o_irWriteEn(ir_m), .o_regWriteEn(rw_m),
        .o_aluInputASel(a_m), .o_aluInputBSel(b_m), .o_aluLogicOperation(op_m),
        .o_regWriteDataSel(wd_m), .o_halted(hlt_m), .o_memTimeout(tmo_m),
        .o_state(st_m)
    );

    multicycle_controller #(.MEM_TIMEOUT(4)) dut_t (
        .i_clk(clk), .i_rst_n(rst_n), .i_operand(opcode), .i_funct3(f3),
        .i_funct7bit5(f7), .i_zero(zero), .i_memReady(ready),
        .o_pcWriteEn(pcWe_t), .o_adrSel(adr_t), .o_memReadEn(rd_t),
        .o_memWriteEn(wr_t), .o_irWriteEn(ir_t), .o_regWriteEn(rw_t),
        .o_aluInputASel(a_t), .o_aluInputBSel(b_t), .o_aluLogicOperation(op_t),
        .o_regWriteDataSel(wd_t), .o_halted(hlt_t), .o_memTimeout(tmo_t),
        .o_state(st_t)
    );

    multicycle_controller #(.ILLEGAL_HALT(1'b0)) dut_n (
        .i_clk(clk), .i_rst_n(rst_n), .i_operand(opcode), .i_funct3(f3),
        .i_funct7bit5(f7), .i_zero(zero), .i_memReady(ready),
        .o_pcWriteEn(pcWe_n), .o_adrSel(adr_n), .o_memReadEn(rd_n),
        .o_memWriteEn(wr_n), .o_irWriteEn(ir_n), .o_regWriteEn(rw_n),
        .o_aluInputASel(a_n), .o_aluInputBSel(b_n), .o_aluLogicOperation(op_n),
        .o_regWriteDataSel(wd_n), .o_halted(hlt_n), .o_memTimeout(tmo_n),
        .o_state(st_n)
    );

    logic [17:0] pk_m, pk_t, pk_n;
    assign pk_m = {pcWe_m, adr_m, rd_m, wr_m, ir_m, rw_m, a_m, b_m, op_m, wd_m, hlt_m, tmo_m};
    assign pk_t = {pcWe_t, adr_t, rd_t, wr_t, ir_t, rw_t, a_t, b_t, op_t, wd_t, hlt_t, tmo_t};
    assign pk_n = {pcWe_n, adr_n, rd_n, wr_n, ir_n, rw_n, a_n, b_n, op_n, wd_n, hlt_n, tmo_n};

    function automatic logic [17:0] pk(input logic pcWe, input logic adrSel,
                                       input logic memRd, input logic memWr,
                                       input logic irWe, input logic regWe,
                                       input logic [1:0] aSel, input logic [1:0] bSel,
                                       input logic [3:0] op, input logic [1:0] wd,
                                       input logic halt, input logic tmo);
        return {pcWe, adrSel, memRd, memWr, irWe, regWe, aSel, bSel, op, wd, halt, tmo};
    endfunction

    // Hand-written expected output patterns
    logic [17:0] F_WAIT, F_ACC, DEC, AWB, JALO, MADR, MRD, MWB, MWR, HLT, HLT_TMO;
    initial begin
        F_WAIT  = pk(0, 0, 1, 0, 0, 0, 2'b00, 2'b10, 4'b0000, 2'b10, 0, 0);
        F_ACC   = pk(1, 0, 1, 0, 1, 0, 2'b00, 2'b10, 4'b0000, 2'b10, 0, 0);
        DEC     = pk(0, 0, 0, 0, 0, 0, 2'b01, 2'b01, 4'b0000, 2'b00, 0, 0);
        AWB     = pk(0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 4'b0000, 2'b00, 0, 0);
        JALO    = pk(1, 0, 0, 0, 0, 0, 2'b01, 2'b10, 4'b0000, 2'b00, 0, 0);
        MADR    = pk(0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 4'b0000, 2'b00, 0, 0);
        MRD     = pk(0, 1, 1, 0, 0, 0, 2'b00, 2'b00, 4'b0000, 2'b00, 0, 0);
        MWB     = pk(0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 4'b0000, 2'b01, 0, 0);
        MWR     = pk(0, 1, 0, 1, 0, 0, 2'b00, 2'b00, 4'b0000, 2'b00, 0, 0);
        HLT     = pk(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 4'b0000, 2'b00, 1, 0);
        HLT_TMO = pk(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 4'b0000, 2'b00, 1, 1);
    end

    function automatic logic [17:0] exR(input logic [3:0] op);
        return pk(0, 0, 0, 0, 0, 0, 2'b10, 2'b00, op, 2'b00, 0, 0);
    endfunction
    function automatic logic [17:0] exI(input logic [3:0] op);
        return pk(0, 0, 0, 0, 0, 0, 2'b10, 2'b01, op, 2'b00, 0, 0);
    endfunction
    function automatic logic [17:0] beqO(input logic z);
        return pk(z, 0, 0, 0, 0, 0, 2'b10, 2'b00, 4'b1000, 2'b00, 0, 0);
    endfunction

    // ---------------- scoreboard helpers ----------------
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic setIn(input logic [6:0] opc, input logic [2:0] fn3, input logic fn7,
                         input logic z, input logic rdy);
        opcode = opc;
        f3     = fn3;
        f7     = fn7;
        zero   = z;
        ready  = rdy;
    endtask

    // Check instance m in the current cycle, then advance one clock
    task automatic cycM(input string nm, input stateT st, input logic [17:0] outs);
        #1;
        chk({nm, ".state"}, 32'(st_m), 32'(st));
        chk({nm, ".outs"}, 32'(pk_m), 32'(outs));
        @(negedge clk);
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [6:0]  opc;
        logic [2:0]  fn3;
        logic        fn7;
        logic        z;
        logic        rdy;
        stateT       st;
        logic [17:0] outs;
    } vecT;

    vecT tbl[$];

    task automatic addV(input logic [6:0] opc, input logic [2:0] fn3, input logic fn7,
                        input logic z, input stateT st, input logic [17:0] outs);
        vecT v;
        v.opc = opc; v.fn3 = fn3; v.fn7 = fn7; v.z = z; v.rdy = 1'b1;
        v.st = st; v.outs = outs;
        tbl.push_back(v);
    endtask

    initial begin
        rst_n = 1'b0;
        setIn(OP_RTYPE, 3'b000, 1'b0, 1'b0, 1'b1);
        #1;

        // Build the table: instructions back to back, memory always ready
        // add x3,x1,x2
        addV(OP_RTYPE, 3'b000, 0, 0, FETCH, F_ACC);
        addV(OP_RTYPE, 3'b000, 0, 0, DECODE, DEC);
        addV(OP_RTYPE, 3'b000, 0, 0, EXECUTER, exR(4'b0000));
        addV(OP_RTYPE, 3'b000, 0, 0, ALUWB, AWB);
        // sub
        addV(OP_RTYPE, 3'b000, 1, 0, FETCH, F_ACC);
        addV(OP_RTYPE, 3'b000, 1, 0, DECODE, DEC);
        addV(OP_RTYPE, 3'b000, 1, 0, EXECUTER, exR(4'b1000));
        addV(OP_RTYPE, 3'b000, 1, 0, ALUWB, AWB);
        // or
        addV(OP_RTYPE, 3'b110, 0, 0, FETCH, F_ACC);
        addV(OP_RTYPE, 3'b110, 0, 0, DECODE, DEC);
        addV(OP_RTYPE, 3'b110, 0, 0, EXECUTER, exR(4'b0110));
        addV(OP_RTYPE, 3'b110, 0, 0, ALUWB, AWB);
        // addi with bit 30 set by a negative immediate: must stay add
        addV(OP_ITYPE, 3'b000, 1, 0, FETCH, F_ACC);
        addV(OP_ITYPE, 3'b000, 1, 0, DECODE, DEC);
        addV(OP_ITYPE, 3'b000, 1, 0, EXECUTEI, exI(4'b0000));
        addV(OP_ITYPE, 3'b000, 1, 0, ALUWB, AWB);
        // srai
        addV(OP_ITYPE, 3'b101, 1, 0, FETCH, F_ACC);
        addV(OP_ITYPE, 3'b101, 1, 0, DECODE, DEC);
        addV(OP_ITYPE, 3'b101, 1, 0, EXECUTEI, exI(4'b1101));
        addV(OP_ITYPE, 3'b101, 1, 0, ALUWB, AWB);
        // andi with bit 30 set
        addV(OP_ITYPE, 3'b111, 1, 0, FETCH, F_ACC);
        addV(OP_ITYPE, 3'b111, 1, 0, DECODE, DEC);
        addV(OP_ITYPE, 3'b111, 1, 0, EXECUTEI, exI(4'b0111));
        addV(OP_ITYPE, 3'b111, 1, 0, ALUWB, AWB);
        // beq taken
        addV(OP_BRANCH, 3'b000, 0, 1, FETCH, F_ACC);
        addV(OP_BRANCH, 3'b000, 0, 1, DECODE, DEC);
        addV(OP_BRANCH, 3'b000, 0, 1, BEQ, beqO(1'b1));
        // beq not taken
        addV(OP_BRANCH, 3'b000, 0, 0, FETCH, F_ACC);
        addV(OP_BRANCH, 3'b000, 0, 0, DECODE, DEC);
        addV(OP_BRANCH, 3'b000, 0, 0, BEQ, beqO(1'b0));
        // bne encoding, zero = 1: still handled as beq
        addV(OP_BRANCH, 3'b001, 0, 1, FETCH, F_ACC);
        addV(OP_BRANCH, 3'b001, 0, 1, DECODE, DEC);
        addV(OP_BRANCH, 3'b001, 0, 1, BEQ, beqO(1'b1));
        // jal
        addV(OP_JAL, 3'b000, 0, 0, FETCH, F_ACC);
        addV(OP_JAL, 3'b000, 0, 0, DECODE, DEC);
        addV(OP_JAL, 3'b000, 0, 0, JAL, JALO);
        addV(OP_JAL, 3'b000, 0, 0, ALUWB, AWB);
        // lw
        addV(OP_LOAD, 3'b010, 0, 0, FETCH, F_ACC);
        addV(OP_LOAD, 3'b010, 0, 0, DECODE, DEC);
        addV(OP_LOAD, 3'b010, 0, 0, MEMADR, MADR);
        addV(OP_LOAD, 3'b010, 0, 0, MEMREAD, MRD);
        addV(OP_LOAD, 3'b010, 0, 0, MEMWB, MWB);
        // sw
        addV(OP_STORE, 3'b010, 0, 0, FETCH, F_ACC);
        addV(OP_STORE, 3'b010, 0, 0, DECODE, DEC);
        addV(OP_STORE, 3'b010, 0, 0, MEMADR, MADR);
        addV(OP_STORE, 3'b010, 0, 0, MEMWRITE, MWR);
        addV(OP_RTYPE, 3'b000, 0, 0, FETCH, F_ACC);

        // ---- reset state: outputs forced low even though FETCH would request
        @(negedge clk);
        #1;
        chk("rst.m.state", 32'(st_m), 32'(FETCH));
        chk("rst.m.outs", 32'(pk_m), 32'd0);
        chk("rst.t.outs", 32'(pk_t), 32'd0);
        chk("rst.n.outs", 32'(pk_n), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // ---- table run
        for (int i = 0; i < tbl.size(); i++) begin
            setIn(tbl[i].opc, tbl[i].fn3, tbl[i].fn7, tbl[i].z, tbl[i].rdy);
            cycM($sformatf("vec%0d", i), tbl[i].st, tbl[i].outs);
        end

        // ---- lw with memory stalled for 3 FETCH cycles, 1 MEMREAD cycle
        doReset();
        for (int i = 0; i < 3; i++) begin
            setIn(OP_LOAD, 3'b010, 0, 0, 1'b0);
            cycM($sformatf("lwwait.fetch%0d", i), FETCH, F_WAIT);
        end
        setIn(OP_LOAD, 3'b010, 0, 0, 1'b1);
        cycM("lwwait.accept", FETCH, F_ACC);
        cycM("lwwait.decode", DECODE, DEC);
        cycM("lwwait.memadr", MEMADR, MADR);
        ready = 1'b0;
        cycM("lwwait.rdstall", MEMREAD, MRD);
        ready = 1'b1;
        cycM("lwwait.rdacc", MEMREAD, MRD);
        cycM("lwwait.memwb", MEMWB, MWB);
        cycM("lwwait.back", FETCH, F_ACC);

        // ---- sw timeout on instance t (limit 4)
        doReset();
        setIn(OP_STORE, 3'b010, 0, 0, 1'b1);
        cycM("tmo.fetch", FETCH, F_ACC);
        cycM("tmo.decode", DECODE, DEC);
        cycM("tmo.memadr", MEMADR, MADR);
        ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("tmo.wr%0d.state", i), 32'(st_t), 32'(MEMWRITE));
            chk($sformatf("tmo.wr%0d.outs", i), 32'(pk_t), 32'(MWR));
            @(negedge clk);
        end
        #1;
        chk("tmo.halt.state", 32'(st_t), 32'(HALT));
        chk("tmo.halt.outs", 32'(pk_t), 32'(HLT_TMO));
        // No timeout on instance m: it is still waiting
        chk("tmo.m.state", 32'(st_m), 32'(MEMWRITE));
        chk("tmo.m.outs", 32'(pk_m), 32'(MWR));
        ready = 1'b1;
        @(negedge clk);
        #1;
        chk("tmo.stayhalt.outs", 32'(pk_t), 32'(HLT_TMO));
        rst_n = 1'b0;
        #1;
        chk("tmo.rstclr.outs", 32'(pk_t), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("tmo.after.state", 32'(st_t), 32'(FETCH));
        @(negedge clk);

        // ---- ready arrives in the limit cycle: accept wins
        doReset();
        setIn(OP_STORE, 3'b010, 0, 0, 1'b1);
        cycM("lim.fetch", FETCH, F_ACC);
        cycM("lim.decode", DECODE, DEC);
        cycM("lim.memadr", MEMADR, MADR);
        ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
        end
        ready = 1'b1;
        #1;
        chk("lim.last.outs", 32'(pk_t), 32'(MWR));
        @(negedge clk);
        #1;
        chk("lim.next.state", 32'(st_t), 32'(FETCH));
        chk("lim.next.outs", 32'(pk_t), 32'(F_ACC));
        @(negedge clk);

        // ---- illegal opcode: m halts, n returns to FETCH
        doReset();
        setIn(7'b1111111, 3'b000, 0, 0, 1'b1);
        @(negedge clk);
        #1;
        chk("ill.m.decode", 32'(pk_m), 32'(DEC));
        chk("ill.n.decode", 32'(pk_n), 32'(DEC));
        @(negedge clk);
        #1;
        chk("ill.m.state", 32'(st_m), 32'(HALT));
        chk("ill.m.outs", 32'(pk_m), 32'(HLT));
        chk("ill.n.state", 32'(st_n), 32'(FETCH));
        @(negedge clk);
        #1;
        chk("ill.m.stay", 32'(st_m), 32'(HALT));
        @(negedge clk);

        // ---- async reset in the middle of MEMREAD
        doReset();
        setIn(OP_LOAD, 3'b010, 0, 0, 1'b1);
        cycM("arst.fetch", FETCH, F_ACC);
        cycM("arst.decode", DECODE, DEC);
        cycM("arst.memadr", MEMADR, MADR);
        ready = 1'b0;
        #1;
        chk("arst.before.rd", 32'(rd_m), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst.during.rd", 32'(rd_m), 32'd0);
        chk("arst.during.state", 32'(st_m), 32'(FETCH));
        @(negedge clk);
        rst_n = 1'b1;
        cycM("arst.restart", FETCH, F_WAIT);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
